// File: rtl/axis_ram_reader.sv
// Purpose : streams a RAM ring buffer out over AXI4-Stream, reading it with
//           16-beat AXI3 INCR bursts and wrapping at 2^ADDR_WIDTH words forever.
// Latency : an R beat shows up on m_axis one cycle after it is accepted.
// Backpressure: a credit counter (FIFO occupancy + words in flight) only lets a
//           burst issue while 16 FIFO slots are guaranteed free, so rready stays 1
//           and no R beat is ever dropped; m_axis_tready stalls simply hold the data.
// Ports   : aclk/aresetn (sync, active-low); cfg_data = ring base byte address;
//           sts_data = words delivered (mod 2^ADDR_WIDTH); m_axi_ar*/m_axi_r* = AXI3
//           read master; m_axis_* = output stream.
// Option  : define AXIS_RAM_READER_TLAST_EN to add m_axis_tlast, which marks the
//           ring's last word.
module axis_ram_reader #(
  parameter int ADDR_WIDTH       = 20,
  parameter int AXI_ID_WIDTH     = 6,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int AXIS_TDATA_WIDTH = 64
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   cfg_data,
  output logic [ADDR_WIDTH-1:0]       sts_data,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [3:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic [1:0]                  m_axi_arburst,
  output logic [3:0]                  m_axi_arcache,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic                        m_axi_rlast,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
`ifdef AXIS_RAM_READER_TLAST_EN
  ,
  output logic                        m_axis_tlast
`endif
);

  localparam int PTR_W = 9;   // 512-entry FIFO
  localparam int CNT_W = 10;  // occupancy / credit range 0..512
  localparam logic [CNT_W-1:0] ISSUE_LIMIT = CNT_W'(496);  // 512 - one burst
  localparam logic [CNT_W-1:0] BURST_CREDIT = CNT_W'(16);
  localparam logic [2:0] AXI_SIZE = (AXI_DATA_WIDTH == 64) ? 3'd3 : 3'd2;

  typedef enum logic {
    IDLE,
    ADDR
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]            credit;
  logic                        issue;
  logic                        ar_fire;
  logic [ADDR_WIDTH-1:0]       word_ptr;
  logic [AXI_ID_WIDTH-1:0]     arid_q;

  logic [AXIS_TDATA_WIDTH-1:0] mem [0:(1<<PTR_W)-1];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [CNT_W-1:0]            count;
  logic                        fifo_wr;
  logic                        pop;

  // rid and rlast carry no information this block needs: credits already bound
  // what is in flight, and beats of a burst arrive in address order.
  logic unused_ok;
  assign unused_ok = ^{1'b0, m_axi_rid, m_axi_rlast, m_axi_rdata};

  // ---------------------------------------------------------------- AR FSM
  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    issue         = 1'b0;
    m_axi_arvalid = 1'b0;
    case (state_q)
      IDLE: begin
        // Credit is reserved at the decision edge, not at acceptance, so a
        // burst waiting on arready is already accounted for.
        if (credit <= ISSUE_LIMIT) begin
          issue   = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ar_fire = m_axi_arvalid & m_axi_arready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      word_ptr <= '0;
      arid_q   <= '0;
    end else if (ar_fire) begin
      word_ptr <= word_ptr + ADDR_WIDTH'(16);
      arid_q   <= arid_q + 1'b1;
    end
  end

  assign m_axi_arid    = arid_q;
  assign m_axi_araddr  = cfg_data + (AXI_ADDR_WIDTH'(word_ptr) << AXI_SIZE);
  assign m_axi_arlen   = 4'd15;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_rready  = 1'b1;

  // ---------------------------------------------------------------- FIFO
  // First-word-fall-through: the head is read combinationally so a beat
  // written at one edge is visible on m_axis right after it.  Credits keep
  // writes from ever hitting a full FIFO, and a pop needs a non-empty FIFO,
  // so simultaneous write and pop always both succeed.
  assign fifo_wr       = m_axi_rvalid;
  assign m_axis_tvalid = (count != '0);
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (aresetn && fifo_wr) mem[wr_ptr] <= m_axi_rdata[AXIS_TDATA_WIDTH-1:0];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      credit   <= '0;
      sts_data <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count    <= count + CNT_W'(fifo_wr) - CNT_W'(pop);
      // An R beat moves a word from "in flight" to "buffered": net zero.
      credit   <= credit + (issue ? BURST_CREDIT : '0) - CNT_W'(pop);
      sts_data <= sts_data + ADDR_WIDTH'(pop);
    end
  end

`ifdef AXIS_RAM_READER_TLAST_EN
  // sts_data equals the ring index of the word currently at the head.
  assign m_axis_tlast = m_axis_tvalid & (&sts_data);
`endif

endmodule

// File: tb/tb_axis_ram_reader.sv
module tb_axis_ram_reader;
  localparam int AW = 6;
  localparam logic [31:0] CFG = 32'h1E00_0000;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] cfg_data = CFG;
  logic [AW-1:0] sts_data;
  logic [5:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [3:0]  m_axi_arcache;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [5:0]  m_axi_rid;
  logic [63:0] m_axi_rdata;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
`ifdef AXIS_RAM_READER_TLAST_EN
  logic        m_axis_tlast;
`endif

  always #5 aclk = ~aclk;

  axis_ram_reader #(
    .ADDR_WIDTH(AW), .AXI_ID_WIDTH(6), .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(64), .AXIS_TDATA_WIDTH(64)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_data(cfg_data), .sts_data(sts_data),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arcache(m_axi_arcache), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
`ifdef AXIS_RAM_READER_TLAST_EN
    , .m_axis_tlast(m_axis_tlast)
`endif
  );

  int checks = 0;
  int errors = 0;

  // bench-side memory / stream model state
  int ar_mode = 1;      // 0 ready, 1 stall, 2 random
  int t_mode = 0;       // 0 low, 1 high, 2 random, 3 budgeted
  int pop_budget = 0;
  bit r_rand = 0;
  bit stray_r = 0;
  logic [31:0] ar_addr_log[$];
  int          ar_id_log[$];
  logic [31:0] pend_q[$];
  int          r_beat = 0;
  logic [63:0] got_dat[$];
  int          got_sts[$];
  bit          got_last[$];
  int ar_cnt = 0, popped = 0, beats = 0;
  int max_track = 0, max_occ = 0;
  int first_r_cyc = -1, first_tv_cyc = -1, cyc = 0;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'h5A5A_1234, a};
  endfunction

  function automatic logic [63:0] exp_word(input int k);
    logic [31:0] a;
    a = CFG + 32'((k % 64) * 8);
    return mem_word(a);
  endfunction

  // AXI slave + stream sink, acting 2 time units after each falling edge
  initial begin
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rlast = 1'b0; m_axi_rid = '0; m_axis_tready = 1'b0;
    forever begin
      @(negedge aclk); #2;
      cyc++;
      if (!aresetn) begin
        pend_q.delete();
        r_beat = 0;
        m_axi_arready = 1'b0;
        m_axis_tready = 1'b0;
        m_axi_rvalid = stray_r;
        m_axi_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        m_axi_rlast = 1'b0;
      end else begin
        case (t_mode)
          0: m_axis_tready = 1'b0;
          1: m_axis_tready = 1'b1;
          2: m_axis_tready = 1'($urandom_range(0, 1));
          default: m_axis_tready = (pop_budget > 0);
        endcase
        if (m_axis_tvalid && m_axis_tready) begin
          got_dat.push_back(m_axis_tdata);
          got_sts.push_back(int'(sts_data));
`ifdef AXIS_RAM_READER_TLAST_EN
          got_last.push_back(m_axis_tlast);
`else
          got_last.push_back(1'b0);
`endif
          popped++;
          if (t_mode == 3) pop_budget--;
        end
        if (first_tv_cyc < 0 && m_axis_tvalid) first_tv_cyc = cyc;
        if (pend_q.size() > 0 && (!r_rand || $urandom_range(0, 1) == 1)) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata = mem_word(pend_q[0] + 32'(r_beat * 8));
          m_axi_rlast = (r_beat == 15);
          beats++;
          if (first_r_cyc < 0) first_r_cyc = cyc;
          r_beat++;
          if (r_beat == 16) begin
            r_beat = 0;
            void'(pend_q.pop_front());
          end
        end else begin
          m_axi_rvalid = 1'b0;
          m_axi_rlast = 1'b0;
        end
        case (ar_mode)
          0: m_axi_arready = 1'b1;
          1: m_axi_arready = 1'b0;
          default: m_axi_arready = 1'($urandom_range(0, 1));
        endcase
        if (m_axi_arvalid && m_axi_arready) begin
          ar_addr_log.push_back(m_axi_araddr);
          ar_id_log.push_back(int'(m_axi_arid));
          pend_q.push_back(m_axi_araddr);
          ar_cnt++;
        end
        if (ar_cnt * 16 - popped > max_track) max_track = ar_cnt * 16 - popped;
        if (beats - popped > max_occ) max_occ = beats - popped;
      end
    end
  end

  task automatic tick();
    @(negedge aclk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(pend_q.size() == 0 && r_beat == 0 && !m_axi_arvalid && beats - popped == 512)
           && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_idle_timeout: occupancy %0d required 512", tag, beats - popped);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    stray_r = 1'b1;
    repeat (4) tick();
    checks += 5;
    if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b want 0", m_axi_arvalid); end
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
    if (m_axi_arid !== 6'd0) begin errors++; $display("FAIL rst_arid: got %0d want 0", m_axi_arid); end
    if (sts_data !== 6'd0) begin errors++; $display("FAIL rst_sts: got %0d want 0", sts_data); end
    if (m_axi_rready !== 1'b1) begin errors++; $display("FAIL rst_rready: got %b want 1", m_axi_rready); end
`ifdef AXIS_RAM_READER_TLAST_EN
    checks++;
    if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
`endif
    stray_r = 1'b0;
  endtask

  task automatic test_ar_stall();
    ar_mode = 1;
    t_mode = 1;
    aresetn = 1'b1;
    tick();
    checks += 3;
    if (m_axi_arvalid !== 1'b1) begin errors++; $display("FAIL first_arvalid: got %b want 1", m_axi_arvalid); end
    if (m_axi_araddr !== CFG) begin errors++; $display("FAIL first_araddr: got %h want %h", m_axi_araddr, CFG); end
    if (m_axi_arid !== 6'd0) begin errors++; $display("FAIL first_arid: got %0d want 0", m_axi_arid); end
    checks += 5;
    if (m_axi_arlen !== 4'd15) begin errors++; $display("FAIL arlen: got %0d want 15", m_axi_arlen); end
    if (m_axi_arsize !== 3'd3) begin errors++; $display("FAIL arsize: got %0d want 3", m_axi_arsize); end
    if (m_axi_arburst !== 2'b01) begin errors++; $display("FAIL arburst: got %b want 01", m_axi_arburst); end
    if (m_axi_arcache !== 4'b0011) begin errors++; $display("FAIL arcache: got %b want 0011", m_axi_arcache); end
    if (m_axi_rready !== 1'b1) begin errors++; $display("FAIL rready: got %b want 1", m_axi_rready); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks += 4;
      if (m_axi_arvalid !== 1'b1) begin errors++; $display("FAIL stall_arvalid c%0d: got %b want 1", i, m_axi_arvalid); end
      if (m_axi_araddr !== CFG) begin errors++; $display("FAIL stall_araddr c%0d: got %h want %h", i, m_axi_araddr, CFG); end
      if (m_axi_arid !== 6'd0) begin errors++; $display("FAIL stall_arid c%0d: got %0d want 0", i, m_axi_arid); end
      if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL stall_tvalid c%0d: got %b want 0", i, m_axis_tvalid); end
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr [5];
    int n;
    exp_addr = '{32'h1E00_0000, 32'h1E00_0080, 32'h1E00_0100, 32'h1E00_0180, 32'h1E00_0000};
    ar_mode = 0;
    t_mode = 1;
    n = 0;
    while (!(ar_cnt >= 5 && popped >= 80) && n < 2000) begin tick(); n++; end
    checks++;
    if (n >= 2000) begin errors++; $display("FAIL stream_timeout: ars %0d words %0d want 5/80", ar_cnt, popped); end
    for (int i = 0; i < 5 && i < ar_addr_log.size(); i++) begin
      checks += 2;
      if (ar_addr_log[i] !== exp_addr[i]) begin errors++; $display("FAIL ar_addr[%0d]: got %h want %h", i, ar_addr_log[i], exp_addr[i]); end
      if (ar_id_log[i] != i) begin errors++; $display("FAIL ar_id[%0d]: got %0d want %0d", i, ar_id_log[i], i); end
    end
    checks++;
    if (first_tv_cyc < 0 || first_r_cyc < 0 || first_tv_cyc - first_r_cyc > 1) begin
      errors++;
      $display("FAIL r_to_tvalid_latency: got %0d cycles want <=1", first_tv_cyc - first_r_cyc);
    end
    for (int k = 0; k < 80 && k < got_dat.size(); k++) begin
      checks += 2;
      if (got_dat[k] !== exp_word(k)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", k, got_dat[k], exp_word(k)); end
      if (got_sts[k] != k % 64) begin errors++; $display("FAIL stream_sts[%0d]: got %0d want %0d", k, got_sts[k], k % 64); end
`ifdef AXIS_RAM_READER_TLAST_EN
      checks++;
      if (got_last[k] != (k % 64 == 63)) begin errors++; $display("FAIL stream_tlast[%0d]: got %b want %b", k, got_last[k], k % 64 == 63); end
`endif
    end
  endtask

  task automatic test_backpressure();
    int a0, p0;
    bit saw_ar;
    t_mode = 0;
    wait_idle("bp");
    checks += 2;
    if (beats - popped != 512) begin errors++; $display("FAIL bp_buffered: got %0d want 512", beats - popped); end
    if (ar_cnt * 16 - popped != 512) begin errors++; $display("FAIL bp_credit: got %0d want 512", ar_cnt * 16 - popped); end
    a0 = ar_cnt;
    p0 = popped;
    saw_ar = 0;
    repeat (50) begin
      tick();
      if (m_axi_arvalid) saw_ar = 1;
    end
    checks += 3;
    if (saw_ar) begin errors++; $display("FAIL bp_extra_arvalid: got 1 want 0"); end
    if (ar_cnt != a0) begin errors++; $display("FAIL bp_ar_count: got %0d want %0d", ar_cnt, a0); end
    if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid: got %b want 1", m_axis_tvalid); end
    pop_budget = 16;
    t_mode = 3;
    repeat (60) tick();
    t_mode = 0;
    checks += 3;
    if (popped != p0 + 16) begin errors++; $display("FAIL bp_pops: got %0d want %0d", popped - p0, 16); end
    if (ar_cnt != a0 + 1) begin errors++; $display("FAIL bp_new_ar: got %0d want 1", ar_cnt - a0); end
    if (beats - popped != 512) begin errors++; $display("FAIL bp_refill: got %0d want 512", beats - popped); end
  endtask

  task automatic test_random();
    int target, n;
    r_rand = 1;
    ar_mode = 2;
    t_mode = 2;
    target = popped + 10000;
    n = 0;
    while (popped < target && n < 60000) begin tick(); n++; end
    checks++;
    if (n >= 60000) begin errors++; $display("FAIL rand_timeout: words %0d want %0d", popped, target); end
    for (int k = 0; k < got_dat.size(); k++) begin
      checks += 2;
      if (got_dat[k] !== exp_word(k)) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", k, got_dat[k], exp_word(k)); end
      if (got_sts[k] != k % 64) begin errors++; $display("FAIL rand_sts[%0d]: got %0d want %0d", k, got_sts[k], k % 64); end
`ifdef AXIS_RAM_READER_TLAST_EN
      checks++;
      if (got_last[k] != (k % 64 == 63)) begin errors++; $display("FAIL rand_tlast[%0d]: got %b want %b", k, got_last[k], k % 64 == 63); end
`endif
    end
    checks += 2;
    if (max_track > 512) begin errors++; $display("FAIL rand_credit_max: got %0d want <=512", max_track); end
    if (max_occ > 512) begin errors++; $display("FAIL rand_occupancy_max: got %0d want <=512", max_occ); end
    r_rand = 0;
  endtask

  task automatic test_reset_midstream();
    int n;
    ar_mode = 0;
    t_mode = 0;
    wait_idle("rst6");
    aresetn = 1'b0;
    tick();
    ar_addr_log.delete(); ar_id_log.delete();
    got_dat.delete(); got_sts.delete(); got_last.delete();
    ar_cnt = 0; popped = 0; beats = 0; first_r_cyc = -1; first_tv_cyc = -1;
    checks += 4;
    if (m_axi_arvalid !== 1'b0) begin errors++; $display("FAIL rst6_arvalid: got %b want 0", m_axi_arvalid); end
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst6_tvalid: got %b want 0", m_axis_tvalid); end
    if (sts_data !== 6'd0) begin errors++; $display("FAIL rst6_sts: got %0d want 0", sts_data); end
    if (m_axi_arid !== 6'd0) begin errors++; $display("FAIL rst6_arid: got %0d want 0", m_axi_arid); end
    aresetn = 1'b1;
    tick();
    checks += 3;
    if (m_axi_arvalid !== 1'b1) begin errors++; $display("FAIL rst6_first_arvalid: got %b want 1", m_axi_arvalid); end
    if (m_axi_araddr !== CFG) begin errors++; $display("FAIL rst6_araddr: got %h want %h", m_axi_araddr, CFG); end
    if (m_axi_arid !== 6'd0) begin errors++; $display("FAIL rst6_first_arid: got %0d want 0", m_axi_arid); end
    t_mode = 1;
    n = 0;
    while (popped < 20 && n < 500) begin tick(); n++; end
    checks++;
    if (n >= 500) begin errors++; $display("FAIL rst6_timeout: words %0d want 20", popped); end
    for (int k = 0; k < 20 && k < got_dat.size(); k++) begin
      checks += 2;
      if (got_dat[k] !== exp_word(k)) begin errors++; $display("FAIL rst6_data[%0d]: got %h want %h", k, got_dat[k], exp_word(k)); end
      if (got_sts[k] != k) begin errors++; $display("FAIL rst6_sts[%0d]: got %0d want %0d", k, got_sts[k], k); end
    end
  endtask

  initial begin
    test_reset();
    test_ar_stall();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
